// File: rtl/arb_mux_reg_if.sv
// Handshake bundle for arb_mux_reg: NUM_IN producer channels into one registered consumer port.
interface arb_mux_reg_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_src;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/arb_mux_reg.sv
// N-channel valid/ready mux with external select (MODE 0) or round-robin (MODE 1) and a one-entry output register.
// Optional macro ARB_MUX_XFER_CNT_EN adds a 32-bit output-handshake counter port xfer_count.
module arb_mux_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic         clk,
  input  logic         reset,
  arb_mux_reg_if.slave bus
`ifdef ARB_MUX_XFER_CNT_EN
  ,
  output logic [31:0]  xfer_count
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic [NUM_IN-1:0] in_ready_c;
  int unsigned      idx;

  assign load_en = !out_valid_q || bus.out_ready;

  // MODE 0 compares sel against each legal index, so out-of-range sel never matches.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (MODE == 0) begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NUM_IN; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
          if (!grant_vld && idx == k && bus.in_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
    end
  end

  assign xfer = !reset && load_en && grant_vld;

  always_comb begin
    grant_data = '0;
    in_ready_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data    = bus.in_data[k*WIDTH +: WIDTH];
        in_ready_c[k] = xfer;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      if (MODE != 0) ptr_d = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;

`ifdef ARB_MUX_XFER_CNT_EN
  logic [31:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: one external-select instance (SEL_W=3) and one round-robin instance, scoreboard-checked.
module tb_arb_mux_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_mux_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(3)) if0 ();
  arb_mux_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if1 ();

`ifdef ARB_MUX_XFER_CNT_EN
  logic [31:0] xc0, xc1;
`endif

  arb_mux_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(3), .MODE(0)) u0 (
    .clk   (clk),
    .reset (rst),
    .bus   (if0)
`ifdef ARB_MUX_XFER_CNT_EN
    , .xfer_count (xc0)
`endif
  );

  arb_mux_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) u1 (
    .clk   (clk),
    .reset (rst),
    .bus   (if1)
`ifdef ARB_MUX_XFER_CNT_EN
    , .xfer_count (xc1)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vt[9];
  int   rr_src[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
  int   checks  = 0;
  int   errors  = 0;
  int   pushes0 = 0;
  int   pushes1 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] d1(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  task automatic push0(input logic [31:0] d, input logic [2:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    q0.push_back(e);
    pushes0++;
  endtask

  task automatic push1(input logic [31:0] d, input logic [2:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    q1.push_back(e);
    pushes1++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv0(input logic [2:0] s, input logic [3:0] v, input logic [31:0] d);
    if0.sel      = s;
    if0.in_valid = v;
    for (int k = 0; k < 4; k++)
      if0.in_data[k*32 +: 32] = (k == int'(s)) ? d : (32'hBAD0_0000 | 32'(k));
  endtask

  // Output handshakes seen just before each rising edge are popped against the scoreboard.
  always @(negedge clk) begin
    if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m0_extra: got data %h, expected no output", if0.out_data);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("m0_data", 64'(if0.out_data), 64'(e.d));
        chk("m0_src", 64'(if0.out_src), 64'(e.s));
      end
    end
    if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m1_extra: got data %h, expected no output", if1.out_data);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("m1_data", 64'(if1.out_data), 64'(e.d));
        chk("m1_src", 64'(if1.out_src), 64'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{3'd2, 4'b0100, 32'hDEAD_BEEF, 4'b0100};
    vt[1] = '{3'd5, 4'b1111, 32'h5555_5555, 4'b0000};
    vt[2] = '{3'd0, 4'b0001, 32'h1234_5678, 4'b0001};
    vt[3] = '{3'd1, 4'b1101, 32'h7777_7777, 4'b0000};
    vt[4] = '{3'd3, 4'b1000, 32'hCAFE_F00D, 4'b1000};
    vt[5] = '{3'd1, 4'b0010, 32'h0BAD_C0DE, 4'b0010};
    vt[6] = '{3'd7, 4'b1111, 32'h6666_6666, 4'b0000};
    vt[7] = '{3'd3, 4'b0111, 32'h8888_8888, 4'b0000};
    vt[8] = '{3'd2, 4'b1111, 32'h5A5A_5A5A, 4'b0100};

    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if1.sel       = '0;
    for (int k = 0; k < 4; k++) if1.in_data[k*32 +: 32] = d1(k);
    if1.in_valid = 4'hF;
    drv0(3'd0, 4'hF, 32'hA0A0_A0A0);
    rst = 1'b1;

    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid0", 64'(if0.out_valid), 64'(1'b0));
      chk("rst_data0", 64'(if0.out_data), 64'(32'h0));
      chk("rst_src0", 64'(if0.out_src), 64'(3'd0));
      chk("rst_ready0", 64'(if0.in_ready), 64'(4'h0));
      chk("rst_valid1", 64'(if1.out_valid), 64'(1'b0));
      chk("rst_ready1", 64'(if1.in_ready), 64'(4'h0));
    end

    rst = 1'b0;
    #1;
    chk("first_ready0", 64'(if0.in_ready), 64'(4'b0001));
    chk("first_ready1", 64'(if1.in_ready), 64'(4'b0001));
    push0(32'hA0A0_A0A0, 3'd0);
    push1(d1(0), 3'd0);
    tick();
    chk("first_valid0", 64'(if0.out_valid), 64'(1'b1));
    chk("first_valid1", 64'(if1.out_valid), 64'(1'b1));
    if1.in_valid = 4'h0;

    for (int i = 0; i < 9; i++) begin
      drv0(vt[i].sel, vt[i].valid, vt[i].data);
      #1;
      chk($sformatf("sel_ready_%0d", i), 64'(if0.in_ready), 64'(vt[i].exp_ready));
      if (vt[i].exp_ready != 4'h0) push0(vt[i].data, vt[i].sel);
      tick();
      chk($sformatf("sel_valid_%0d", i), 64'(if0.out_valid), 64'(vt[i].exp_ready != 4'h0));
    end

    drv0(3'd0, 4'b0001, 32'h1111_1111);
    #1;
    chk("bp_load_ready", 64'(if0.in_ready), 64'(4'b0001));
    push0(32'h1111_1111, 3'd0);
    tick();
    if0.out_ready = 1'b0;
    drv0(3'd0, 4'b0001, 32'h2222_2222);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drv0(3'd2, 4'b0101, 32'h3333_3333);
      if (c == 2) drv0(3'd0, 4'b0001, 32'h2222_2222);
      #1;
      chk($sformatf("bp_ready_%0d", c), 64'(if0.in_ready), 64'(4'h0));
      chk($sformatf("bp_data_%0d", c), 64'(if0.out_data), 64'(32'h1111_1111));
      chk($sformatf("bp_valid_%0d", c), 64'(if0.out_valid), 64'(1'b1));
      tick();
    end
    if0.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(if0.in_ready), 64'(4'b0001));
    push0(32'h2222_2222, 3'd0);
    tick();
    chk("bp_after_valid", 64'(if0.out_valid), 64'(1'b1));
    chk("bp_after_data", 64'(if0.out_data), 64'(32'h2222_2222));
    drv0(3'd2, 4'b0000, 32'h0);
    tick();
    chk("drain_valid", 64'(if0.out_valid), 64'(1'b0));
    chk("drain_hold_data", 64'(if0.out_data), 64'(32'h2222_2222));

    if1.in_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("rst2_ready1", 64'(if1.in_ready), 64'(4'h0));
    tick();
    chk("rst2_valid1", 64'(if1.out_valid), 64'(1'b0));
    rst = 1'b0;
    pushes0 = 0;
    pushes1 = 0;

    for (int i = 0; i < 9; i++) begin
      if1.in_valid = (i < 5) ? 4'hF : 4'b1010;
      #1;
      chk($sformatf("rr_ready_%0d", i), 64'(if1.in_ready), 64'(4'b0001 << rr_src[i]));
      push1(d1(rr_src[i]), 3'(rr_src[i]));
      tick();
    end

    if1.in_valid = 4'b0010;
    #1;
    chk("st_pre_ready", 64'(if1.in_ready), 64'(4'b0010));
    push1(d1(1), 3'd1);
    tick();
    if1.out_ready = 1'b0;
    if1.in_valid  = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("st_ready_%0d", c), 64'(if1.in_ready), 64'(4'h0));
      chk($sformatf("st_src_%0d", c), 64'(if1.out_src), 64'(2'd1));
      tick();
    end
    if1.out_ready = 1'b1;
    #1;
    chk("st_release_ready", 64'(if1.in_ready), 64'(4'b0100));
    push1(d1(2), 3'd2);
    tick();
    chk("st_src_after", 64'(if1.out_src), 64'(2'd2));
    chk("st_next_ready", 64'(if1.in_ready), 64'(4'b1000));
    push1(d1(3), 3'd3);
    tick();
    chk("st_next_src", 64'(if1.out_src), 64'(2'd3));
    if1.in_valid = 4'h0;
    tick();
    tick();

`ifdef ARB_MUX_XFER_CNT_EN
    chk("cnt1", 64'(xc1), 64'(pushes1));
    chk("cnt0", 64'(xc0), 64'(pushes0));
    force u0.xfer_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u0.xfer_cnt_q;
    drv0(3'd1, 4'b0010, 32'hAAAA_0001);
    push0(32'hAAAA_0001, 3'd1);
    tick();
    chk("wrap_pre", 64'(xc0), 64'(32'hFFFF_FFFE));
    drv0(3'd1, 4'b0010, 32'hAAAA_0002);
    push0(32'hAAAA_0002, 3'd1);
    tick();
    chk("wrap_max", 64'(xc0), 64'(32'hFFFF_FFFF));
    drv0(3'd1, 4'b0000, 32'h0);
    if0.out_ready = 1'b0;
    tick();
    tick();
    chk("wrap_stall", 64'(xc0), 64'(32'hFFFF_FFFF));
    if0.out_ready = 1'b1;
    tick();
    chk("wrap_zero", 64'(xc0), 64'(32'h0));
`endif

    tick();
    chk("q0_empty", 64'(q0.size()), 64'(0));
    chk("q1_empty", 64'(q1.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
